// File: rtl/esm_pkg.sv
// Shared definitions for the ESM dependency tracker: instruction field positions,
// slot index type and the per-register writer table entry.
package esm_pkg;

  localparam int RD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;
  localparam int REG_FIELD_W = 5;

  localparam int BS_DEFAULT  = 16;
  localparam int SLOT_W      = $clog2(BS_DEFAULT);

  typedef logic [SLOT_W-1:0]      slot_idx_t;
  typedef logic [REG_FIELD_W-1:0] reg_idx_t;

  typedef struct packed {
    logic      live;
    slot_idx_t writer_idx;
  } irt_entry_t;

  function automatic reg_idx_t reg_field(input logic [31:0] instr, input int lsb);
    return instr[lsb +: REG_FIELD_W];
  endfunction

endpackage

// File: rtl/esm_prio_enc.sv
// Lowest-set-bit encoder with an any-bit flag; used to pick the free slot.
module esm_prio_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Scan downwards so the lowest requesting bit is the final winner.
  always_comb begin
    idx = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx = req[i] ? IW'(i) : idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/esm_dep_tracker.sv
// Instruction dependency tracker: self-allocating slot buffer with a BS x BS
// dependency matrix, register-to-writer table, per-slot retire and flush.
module esm_dep_tracker
  import esm_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int BS        = 16,
  parameter int REGNUM    = 32,
  parameter int TRACK_WAW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr_in,
  input  logic                  reg_write,
  input  logic                  alu_src,
  output logic [$clog2(BS)-1:0] alloc_idx,
  input  logic                  retire_valid,
  input  logic [$clog2(BS)-1:0] retire_idx,
  input  logic                  flush,
  output logic [BS-1:0]         valid_entries,
  output logic [BS-1:0]         independent_instr
);

  localparam int   IDX_W  = $clog2(BS);
  localparam logic WAW_EN = (TRACK_WAW != 0);

  typedef struct packed {
    logic             live;
    logic [IDX_W-1:0] writer_idx;
  } irt_t;

  logic [BS-1:0]    valid_r, valid_n_s;
  logic [BS-1:0]    indep_r, indep_n_s;
  logic [BS-1:0]    dep_r   [BS];
  logic [BS-1:0]    dep_n_s [BS];
  irt_t             irt_r   [REGNUM];
  irt_t             irt_n_s [REGNUM];

  logic             any_free_s;
  logic [IDX_W-1:0] alloc_s;
  logic             insert_s, retire_s, wr_irt_s;
  logic [BS-1:0]    ret_mask_s, ins_mask_s, row_new_s;
  reg_idx_t         rd_s, rs1_s, rs2_s;
  logic             unused_fields_s;

  esm_prio_enc #(.N(BS)) u_alloc (
    .req (~valid_r),
    .idx (alloc_s),
    .any (any_free_s)
  );

  assign in_ready          = any_free_s;
  assign alloc_idx         = alloc_s;
  assign valid_entries     = valid_r;
  assign independent_instr = indep_r;

  assign rd_s  = instr_in[RD_LSB  +: REG_FIELD_W];
  assign rs1_s = instr_in[RS1_LSB +: REG_FIELD_W];
  assign rs2_s = instr_in[RS2_LSB +: REG_FIELD_W];
  assign unused_fields_s = ^{instr_in[INSTR_W-1:RS2_LSB+REG_FIELD_W],
                             instr_in[RS1_LSB-1:RD_LSB+REG_FIELD_W],
                             instr_in[RD_LSB-1:0]};

  // Flush squashes any concurrent insert or retire; retiring an empty slot is a no-op.
  assign insert_s = in_valid & any_free_s & ~flush;
  assign retire_s = retire_valid & valid_r[retire_idx] & ~flush;
  assign wr_irt_s = insert_s & reg_write & (|rd_s);

  // One-hot column for a live writer, ignoring a writer that is retiring this cycle.
  function automatic logic [BS-1:0] src_hit(input logic en, input irt_t e,
                                            input logic ret, input logic [IDX_W-1:0] ret_idx);
    logic [BS-1:0] v;
    v = {BS{1'b0}};
    v[e.writer_idx] = en & e.live & ~(ret & (e.writer_idx == ret_idx));
    return v;
  endfunction

  // One-hot masks for the slot being retired and the slot being allocated.
  always_comb begin
    ret_mask_s = {BS{1'b0}};
    ins_mask_s = {BS{1'b0}};
    ret_mask_s[retire_idx] = retire_s;
    ins_mask_s[alloc_s]    = insert_s;
  end

  // New row looks up the pre-insert table, so an instruction never depends on itself.
  always_comb begin
    row_new_s = src_hit(|rs1_s, irt_r[rs1_s], retire_s, retire_idx)
              | src_hit(~alu_src & (|rs2_s), irt_r[rs2_s], retire_s, retire_idx)
              | src_hit(WAW_EN & reg_write & (|rd_s), irt_r[rd_s], retire_s, retire_idx);
  end

  // Next-state dependency matrix and occupancy: retire first, then insert.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      if (flush) begin
        dep_n_s[i] = {BS{1'b0}};
      end else if (ins_mask_s[i]) begin
        dep_n_s[i] = row_new_s;
      end else if (ret_mask_s[i]) begin
        dep_n_s[i] = {BS{1'b0}};
      end else begin
        dep_n_s[i] = dep_r[i] & ~ret_mask_s;
      end
    end
    if (flush) begin
      valid_n_s = {BS{1'b0}};
    end else begin
      valid_n_s = (valid_r & ~ret_mask_s) | ins_mask_s;
    end
  end

  // Next-state register writer table.
  always_comb begin
    for (int r = 0; r < REGNUM; r++) begin
      if (flush) begin
        irt_n_s[r] = {(IDX_W + 1){1'b0}};
      end else if (wr_irt_s && (rd_s == REG_FIELD_W'(r))) begin
        irt_n_s[r] = '{live: 1'b1, writer_idx: alloc_s};
      end else if (retire_s && (irt_r[r].writer_idx == retire_idx)) begin
        irt_n_s[r] = '{live: 1'b0, writer_idx: irt_r[r].writer_idx};
      end else begin
        irt_n_s[r] = irt_r[r];
      end
    end
  end

  // A slot is issuable when occupied and its row has no outstanding producer.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      indep_n_s[i] = valid_n_s[i] & ~(|dep_n_s[i]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {BS{1'b0}};
      indep_r <= {BS{1'b0}};
      for (int i = 0; i < BS; i++) begin
        dep_r[i] <= {BS{1'b0}};
      end
      for (int r = 0; r < REGNUM; r++) begin
        irt_r[r] <= {(IDX_W + 1){1'b0}};
      end
    end else begin
      valid_r <= valid_n_s;
      indep_r <= indep_n_s;
      for (int i = 0; i < BS; i++) begin
        dep_r[i] <= dep_n_s[i];
      end
      for (int r = 0; r < REGNUM; r++) begin
        irt_r[r] <= irt_n_s[r];
      end
    end
  end

endmodule

// File: tb/tb_esm_dep_tracker.sv
// Scoreboard bench for esm_dep_tracker; a second instance runs with WAW tracking off.
module tb_esm_dep_tracker;

  localparam int S_VALID = 0, S_INDEP = 1, S_READY = 2, S_ALLOC = 3, S_INDEP2 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, reg_write = 1'b0, alu_src = 1'b0;
  logic        retire_valid = 1'b0, flush = 1'b0;
  logic [31:0] instr_in = 32'h0;
  logic [3:0]  retire_idx = 4'h0;

  logic        in_ready, in_ready2;
  logic [3:0]  alloc_idx, alloc_idx2;
  logic [15:0] valid_entries, valid_entries2, indep, indep2;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;
  exp_t sb[$];

  esm_dep_tracker #(.TRACK_WAW(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
    .reg_write(reg_write), .alu_src(alu_src), .alloc_idx(alloc_idx),
    .retire_valid(retire_valid), .retire_idx(retire_idx), .flush(flush),
    .valid_entries(valid_entries), .independent_instr(indep)
  );

  esm_dep_tracker #(.TRACK_WAW(0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .instr_in(instr_in),
    .reg_write(reg_write), .alu_src(alu_src), .alloc_idx(alloc_idx2),
    .retire_valid(retire_valid), .retire_idx(retire_idx), .flush(flush),
    .valid_entries(valid_entries2), .independent_instr(indep2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    logic [4:0] d, a, b;
    d = 5'(rd); a = 5'(rs1); b = 5'(rs2);
    return {7'b0000000, b, a, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_VALID:  return {16'h0, valid_entries};
      S_INDEP:  return {16'h0, indep};
      S_READY:  return {31'h0, in_ready};
      S_ALLOC:  return {28'h0, alloc_idx};
      S_INDEP2: return {16'h0, indep2};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic exp_now(input int sel, input logic [31:0] v, input string nm);
    sb.push_back('{cyc, sel, v, nm});
  endtask

  task automatic exp_next(input int sel, input logic [31:0] v, input string nm);
    sb.push_back('{cyc + 1, sel, v, nm});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0; reg_write = 1'b0; alu_src = 1'b0;
    retire_valid = 1'b0; flush = 1'b0; instr_in = 32'h0; retire_idx = 4'h0;
  endtask

  task automatic ins(input logic [31:0] instr, input logic rw, input logic as);
    in_valid = 1'b1; instr_in = instr; reg_write = rw; alu_src = as;
  endtask

  task automatic ret(input int idx);
    retire_valid = 1'b1; retire_idx = 4'(idx);
  endtask

  // Monitor: pop and compare every expectation that is due this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        logic [31:0] a;
        e = sb.pop_front();
        a = actual(e.sel);
        n_tests++;
        if (a !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.nm, a, e.val, cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    n_tests++;
    if (valid_entries !== 16'h0000) begin
      n_fail++;
      $display("FAIL direct_reset_valid: got 0x%0h expected 0x0", valid_entries);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_reset_ready: got %0b expected 1", in_ready);
    end
    exp_now(S_VALID, 32'h0, "reset_valid");
    exp_now(S_INDEP, 32'h0, "reset_indep");
    exp_now(S_READY, 32'h1, "reset_ready");
    exp_now(S_ALLOC, 32'h0, "reset_alloc");
    tick();

    // ADD x3,x1,x2 lands in slot 0 and is independent.
    ins(mk(3, 1, 2), 1'b1, 1'b0);
    exp_now(S_ALLOC, 32'h0, "t1_alloc");
    exp_next(S_VALID, 32'h1, "t1_valid");
    exp_next(S_INDEP, 32'h1, "t1_indep");
    tick();

    // x4 <- x3 + x5 depends on slot 0.
    ins(mk(4, 3, 5), 1'b1, 1'b0);
    exp_now(S_ALLOC, 32'h1, "t2_alloc");
    exp_next(S_VALID, 32'h3, "t2_valid");
    exp_next(S_INDEP, 32'h1, "t2_raw_dep");
    tick();
    ret(0);
    exp_next(S_VALID, 32'h2, "t2_ret_valid");
    exp_next(S_INDEP, 32'h2, "t2_ret_indep");
    tick();

    // Same-cycle retire of x3's writer and insert of a reader of x3.
    ins(mk(3, 1, 2), 1'b1, 1'b0);
    exp_now(S_ALLOC, 32'h0, "t4_alloc0");
    exp_next(S_INDEP, 32'h3, "t4_setup_indep");
    tick();
    ins(mk(6, 3, 0), 1'b1, 1'b0);
    ret(0);
    exp_now(S_ALLOC, 32'h2, "t4_alloc_pre_retire");
    exp_next(S_VALID, 32'h6, "t4_valid");
    exp_next(S_INDEP, 32'h6, "t4_reader_indep");
    tick();
    ins(mk(8, 3, 0), 1'b1, 1'b0);
    exp_now(S_ALLOC, 32'h0, "t4_alloc_reuse");
    exp_next(S_INDEP, 32'h7, "t4_irt_cleared");
    tick();

    // Flush wins over concurrent insert and retire.
    ins(mk(9, 4, 0), 1'b1, 1'b0);
    ret(1);
    flush = 1'b1;
    exp_next(S_VALID, 32'h0, "t6_valid");
    exp_next(S_INDEP, 32'h0, "t6_indep");
    exp_next(S_READY, 32'h1, "t6_ready");
    exp_next(S_ALLOC, 32'h0, "t6_alloc");
    tick();

    // Self-reference, WAW on x7, immediate operand and RAW through rs2.
    ins(mk(5, 5, 5), 1'b1, 1'b0);
    exp_next(S_INDEP, 32'h1, "self_dep");
    tick();
    ins(mk(7, 1, 2), 1'b1, 1'b0);
    exp_next(S_INDEP, 32'h3, "waw_first");
    tick();
    ins(mk(7, 1, 2), 1'b1, 1'b0);
    exp_now(S_ALLOC, 32'h2, "waw_alloc");
    exp_next(S_VALID, 32'h7, "waw_valid");
    exp_next(S_INDEP, 32'h3, "waw_on");
    exp_next(S_INDEP2, 32'h7, "waw_off");
    tick();
    ins(mk(10, 0, 7), 1'b1, 1'b1);
    exp_next(S_INDEP, 32'hB, "alusrc_imm");
    exp_next(S_INDEP2, 32'hF, "alusrc_imm_raw");
    tick();
    ins(mk(11, 0, 7), 1'b1, 1'b0);
    exp_next(S_INDEP, 32'hB, "rs2_raw");
    exp_next(S_INDEP2, 32'hF, "rs2_raw_nowaw");
    tick();
    ret(9);
    exp_next(S_VALID, 32'h1F, "retire_empty_ignored");
    exp_next(S_INDEP, 32'hB, "retire_empty_indep");
    tick();
    flush = 1'b1;
    exp_next(S_VALID, 32'h0, "flush2_valid");
    tick();

    // Fill all slots with rd=0 instructions.
    for (int k = 0; k < 16; k++) begin
      ins(mk(0, 1, 2), 1'b1, 1'b0);
      exp_now(S_ALLOC, 32'(k), "fill_alloc");
      exp_next(S_VALID, (32'h1 << (k + 1)) - 32'h1, "fill_valid");
      exp_next(S_INDEP, (32'h1 << (k + 1)) - 32'h1, "fill_indep");
      tick();
    end
    ins(mk(0, 1, 2), 1'b1, 1'b0);
    exp_now(S_READY, 32'h0, "full_ready");
    exp_next(S_VALID, 32'hFFFF, "full_ignored");
    tick();
    ret(5);
    exp_next(S_VALID, 32'hFFDF, "full_retire5");
    exp_next(S_ALLOC, 32'h5, "full_alloc5");
    exp_next(S_READY, 32'h1, "full_ready_again");
    tick();
    ins(mk(0, 1, 2), 1'b1, 1'b0);
    exp_next(S_VALID, 32'hFFFF, "refill5");
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_refill_ready: got %0b expected 0", in_ready);
    end
    n_tests++;
    if (valid_entries !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL direct_refill_valid: got 0x%0h expected 0xFFFF", valid_entries);
    end
    n_tests++;
    if (indep !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL direct_refill_indep: got 0x%0h expected 0xFFFF", indep);
    end

    repeat (3) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected 0x%0h", e.nm, e.val);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
